// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI byte arbiter: FSM state encoding,
// owner/grant index constants and a small owner-to-grant helper.
package oled_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_A_IDX = 0;
    localparam int GNT_B_IDX = 1;

    // Owner identifiers (single bit, A = init/command, B = frame stream)
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Grant value when nobody owns the SPI master
    localparam logic [1:0] GNT_NONE = 2'b00;

    // One-hot grant vector for a given owner
    function automatic logic [1:0] owner_to_grant(input logic owner);
        logic [1:0] g;
        g            = GNT_NONE;
        g[GNT_A_IDX] = (owner == OWNER_A);
        g[GNT_B_IDX] = (owner == OWNER_B);
        return g;
    endfunction

endpackage

// File: rtl/oled_spi_arbiter.sv
// Two-requester byte arbiter in front of an SPI master for an OLED panel.
// Requester A carries init/command traffic, B streams frame data. Owners may
// lock the bus for bursts of up to MAX_BURST bytes; a missing send_busy rise
// within START_TO cycles aborts the byte with ack+err.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int START_TO  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       a_lock,
    input  logic       b_lock,
    input  logic       a_dc,
    input  logic       b_dc,
    input  logic [7:0] a_data,
    input  logic [7:0] b_data,
    output logic       a_ack,
    output logic       b_ack,
    output logic       err,
    output logic [1:0] grant,
    output logic       send_en,
    output logic       send_dc,
    output logic [7:0] send_data,
    input  logic       send_busy
);

    // Timer counts 0..START_TO-1 inside WAIT_START
    localparam int TW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(START_TO - 1);

    // Burst counter holds 0..MAX_BURST bytes of the current ownership run
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    state_t          r_state;
    logic            r_owner;
    logic            r_last;
    logic            r_lock;
    logic [BW-1:0]   r_burst;
    logic [TW-1:0]   r_timer;
    logic            r_a_ack;
    logic            r_b_ack;
    logic            r_err;
    logic [1:0]      r_grant;
    logic            r_send_en;
    logic            r_send_dc;
    logic [7:0]      r_send_data;

    logic            w_owner_req;
    logic            w_owner_lock;
    logic            w_lock_keep;
    logic            w_evaluate;
    logic            w_has_win;
    logic            w_win;
    logic            w_win_dc;
    logic [7:0]      w_win_data;

    // Winner selection: a valid lock pins the owner, otherwise sole requester
    // or round-robin against the last served requester.
    always_comb begin
        w_owner_req  = (r_owner == OWNER_B) ? b_req  : a_req;
        w_owner_lock = (r_owner == OWNER_B) ? b_lock : a_lock;
        // Lock survives only while the owner keeps requesting and the burst
        // budget is not yet spent; a spent budget hands the tie to the other side.
        w_lock_keep  = r_lock && w_owner_req && (r_burst < BURST_MAX);
        // An ack in flight this cycle forces a one-cycle gap between bytes
        w_evaluate   = (r_state == ST_IDLE) && !(r_a_ack || r_b_ack);
        w_has_win    = 1'b0;
        w_win        = OWNER_A;
        if (w_lock_keep) begin
            w_has_win = 1'b1;
            w_win     = r_owner;
        end else if (a_req && b_req) begin
            w_has_win = 1'b1;
            w_win     = ~r_last;
        end else if (a_req) begin
            w_has_win = 1'b1;
            w_win     = OWNER_A;
        end else if (b_req) begin
            w_has_win = 1'b1;
            w_win     = OWNER_B;
        end
        w_win_dc   = (w_win == OWNER_B) ? b_dc   : a_dc;
        w_win_data = (w_win == OWNER_B) ? b_data : a_data;
    end

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWNER_A;
            r_last      <= OWNER_B;
            r_lock      <= 1'b0;
            r_burst     <= '0;
            r_timer     <= '0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_grant     <= GNT_NONE;
            r_send_en   <= 1'b0;
            r_send_dc   <= 1'b0;
            r_send_data <= 8'h00;
        end else begin
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_err     <= 1'b0;
            r_send_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_evaluate) begin
                        if (!w_lock_keep) begin
                            r_lock <= 1'b0;
                        end
                        if (w_has_win) begin
                            r_state     <= ST_ISSUE;
                            r_send_en   <= 1'b1;
                            r_send_dc   <= w_win_dc;
                            r_send_data <= w_win_data;
                            r_owner     <= w_win;
                            r_last      <= w_win;
                            r_grant     <= owner_to_grant(w_win);
                            r_burst     <= w_lock_keep ? (r_burst + BW'(1)) : BW'(1);
                        end else begin
                            r_grant <= GNT_NONE;
                            r_burst <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Lock intent is taken from the owner while its byte is issued
                    r_lock  <= w_owner_lock;
                    r_timer <= '0;
                    r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (send_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer == TIMER_LAST) begin
                        // START_TO full cycles without busy: abort the byte
                        r_a_ack <= (r_owner == OWNER_A);
                        r_b_ack <= (r_owner == OWNER_B);
                        r_err   <= 1'b1;
                        r_lock  <= 1'b0;
                        r_burst <= '0;
                        r_grant <= GNT_NONE;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!send_busy) begin
                        r_a_ack <= (r_owner == OWNER_A);
                        r_b_ack <= (r_owner == OWNER_B);
                        if (!r_lock) begin
                            r_grant <= GNT_NONE;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_ack     = r_a_ack;
    assign b_ack     = r_b_ack;
    assign err       = r_err;
    assign grant     = r_grant;
    assign send_en   = r_send_en;
    assign send_dc   = r_send_dc;
    assign send_data = r_send_data;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed scoreboard bench for oled_spi_arbiter. Requesters are queue-driven
// models, an SPI-master model answers send_en with busy, and the expected
// grant order is pushed up front and popped on every send_en.
module tb_oled_spi_arbiter;

    localparam int MAX_BURST = 16;
    localparam int START_TO  = 8;

    typedef struct packed {
        logic       owner;
        logic       dc;
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic       lock;
    } byte_t;

    logic       clk;
    logic       rst;
    logic       a_req, b_req, a_lock, b_lock, a_dc, b_dc;
    logic [7:0] a_data, b_data;
    logic       a_ack, b_ack, err;
    logic [1:0] grant;
    logic       send_en, send_dc;
    logic [7:0] send_data;
    logic       send_busy;

    exp_t  exp_q[$];
    byte_t a_q[$];
    byte_t b_q[$];
    exp_t  cur;
    bit    cur_valid;
    bit    pend_at_ack;
    bit    busy_never;
    bit    a_drop_mid;
    int    busy_len;
    int    busy_cnt;
    int    issue_cyc;
    int    fall_cyc;
    int    last_ack_cyc;
    int    rise_cyc;
    int    cyc;
    int    checks;
    int    errors;

    oled_spi_arbiter #(
        .MAX_BURST(MAX_BURST),
        .START_TO (START_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .b_req    (b_req),
        .a_lock   (a_lock),
        .b_lock   (b_lock),
        .a_dc     (a_dc),
        .b_dc     (b_dc),
        .a_data   (a_data),
        .b_data   (b_data),
        .a_ack    (a_ack),
        .b_ack    (b_ack),
        .err      (err),
        .grant    (grant),
        .send_en  (send_en),
        .send_dc  (send_dc),
        .send_data(send_data),
        .send_busy(send_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic add_exp(input logic o, input logic d, input logic [7:0] dat, input logic e);
        exp_t x;
        x.owner = o;
        x.dc    = d;
        x.data  = dat;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    task automatic push_a(input logic d, input logic [7:0] dat, input logic l);
        byte_t x;
        x.dc   = d;
        x.data = dat;
        x.lock = l;
        a_q.push_back(x);
    endtask

    task automatic push_b(input logic d, input logic [7:0] dat, input logic l);
        byte_t x;
        x.dc   = d;
        x.data = dat;
        x.lock = l;
        b_q.push_back(x);
    endtask

    function automatic logic [1:0] onehot(input logic o);
        return o ? 2'b10 : 2'b01;
    endfunction

    task automatic clear_models();
        a_q.delete();
        b_q.delete();
        exp_q.delete();
        cur_valid   = 1'b0;
        pend_at_ack = 1'b0;
        send_busy   = 1'b0;
        busy_cnt    = 0;
    endtask

    // One clock cycle: sample after the edge, score, then drive next inputs
    task automatic tick();
        logic prev_a_req;
        @(posedge clk);
        #1;
        cyc++;
        if (a_ack || b_ack) begin
            chk("ack_expected", {31'd0, cur_valid}, 32'd1);
            if (cur_valid) begin
                chk("ack_a", {31'd0, a_ack}, {31'd0, cur.owner == 1'b0});
                chk("ack_b", {31'd0, b_ack}, {31'd0, cur.owner});
                chk("ack_err", {31'd0, err}, {31'd0, cur.err});
                if (cur.err) chk("ack_time_timeout", cyc, issue_cyc + START_TO + 1);
                else         chk("ack_time_done", cyc, fall_cyc + 1);
                if (cur.owner == 1'b0) begin
                    if (a_q.size() > 0) void'(a_q.pop_front());
                end else begin
                    if (b_q.size() > 0) void'(b_q.pop_front());
                end
                $display("t=%0d ack owner=%s data=%02h err=%0d", cyc, cur.owner ? "B" : "A", cur.data, err);
                cur_valid    = 1'b0;
                last_ack_cyc = cyc;
                pend_at_ack  = (a_q.size() > 0) || (b_q.size() > 0);
            end
        end else begin
            chk("err_without_ack", {31'd0, err}, 32'd0);
        end
        if (send_en) begin
            if (cur_valid || exp_q.size() == 0) begin
                chk("send_en_unexpected", {31'd0, send_en}, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                chk("issue_grant", {30'd0, grant}, {30'd0, onehot(cur.owner)});
                chk("issue_data", {24'd0, send_data}, {24'd0, cur.data});
                chk("issue_dc", {31'd0, send_dc}, {31'd0, cur.dc});
                if (pend_at_ack) chk("issue_gap_after_ack", cyc - last_ack_cyc, 2);
                pend_at_ack = 1'b0;
                cur_valid   = 1'b1;
                issue_cyc   = cyc;
                if (!busy_never) begin
                    send_busy = 1'b1;
                    busy_cnt  = busy_len;
                end
            end
        end else if (cur_valid) begin
            chk("hold_grant", {30'd0, grant}, {30'd0, onehot(cur.owner)});
            chk("hold_data", {24'd0, send_data}, {24'd0, cur.data});
            chk("hold_dc", {31'd0, send_dc}, {31'd0, cur.dc});
            if (send_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    send_busy = 1'b0;
                    fall_cyc  = cyc;
                end
            end
        end
        prev_a_req = a_req;
        a_req  = (a_q.size() > 0) && !(a_drop_mid && cur_valid && cur.owner == 1'b0);
        a_dc   = (a_q.size() > 0) ? a_q[0].dc   : 1'b0;
        a_data = (a_q.size() > 0) ? a_q[0].data : 8'h00;
        a_lock = (a_q.size() > 0) ? a_q[0].lock : 1'b0;
        b_req  = (b_q.size() > 0);
        b_dc   = (b_q.size() > 0) ? b_q[0].dc   : 1'b0;
        b_data = (b_q.size() > 0) ? b_q[0].data : 8'h00;
        b_lock = (b_q.size() > 0) ? b_q[0].lock : 1'b0;
        if (a_req && !prev_a_req) rise_cyc = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_models();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || cur_valid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0 && !cur_valid) else begin
            errors++;
            $error("FAIL run_done: observed %0d bytes pending expected 0 within %0d cycles", exp_q.size() + (cur_valid ? 1 : 0), budget);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_send_en"}, {31'd0, send_en}, 32'd0);
        chk({tag, "_send_dc"}, {31'd0, send_dc}, 32'd0);
        chk({tag, "_send_data"}, {24'd0, send_data}, 32'd0);
        chk({tag, "_acks"}, {30'd0, a_ack, b_ack}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        a_dc = 1'b0; b_dc = 1'b0; a_data = 8'h00; b_data = 8'h00;
        send_busy = 1'b0; busy_never = 1'b0; a_drop_mid = 1'b0;
        busy_len = 10; busy_cnt = 0; issue_cyc = 0; fall_cyc = 0;
        last_ack_cyc = 0; rise_cyc = 0;
        cur = '0;
        cur_valid = 1'b0; pend_at_ack = 1'b0;

        // Reset state
        do_reset();
        chk_all_zero("reset");

        // Single command byte 0xAE, busy high for 10 cycles
        busy_len = 10;
        push_a(1'b0, 8'hAE, 1'b0);
        add_exp(1'b0, 1'b0, 8'hAE, 1'b0);
        tick();
        tick();
        chk("s030_send_en", {31'd0, send_en}, 32'd1);
        chk("s030_en_latency", cyc, rise_cyc + 1);
        tick();
        chk("s030_en_one_cycle", {31'd0, send_en}, 32'd0);
        run_until_done(100);

        // Both requesting, no lock: strict alternation starting with A
        do_reset();
        busy_len = 3;
        for (int i = 0; i < 4; i++) begin
            push_a(i[0], 8'hA0 + 8'(i), 1'b0);
            push_b(~i[0], 8'hB0 + 8'(i), 1'b0);
            add_exp(1'b0, i[0], 8'hA0 + 8'(i), 1'b0);
            add_exp(1'b1, ~i[0], 8'hB0 + 8'(i), 1'b0);
        end
        run_until_done(400);
        tick();
        tick();
        chk("s031_grant_idle", {30'd0, grant}, 32'd0);

        // Locked A burst of 20 bytes vs one B byte: 16 A, B, remaining 4 A
        do_reset();
        busy_len = 2;
        for (int i = 0; i < 20; i++) push_a(1'b1, 8'(i), 1'b1);
        push_b(1'b0, 8'hBB, 1'b0);
        for (int i = 0; i < 16; i++) add_exp(1'b0, 1'b1, 8'(i), 1'b0);
        add_exp(1'b1, 1'b0, 8'hBB, 1'b0);
        for (int i = 16; i < 20; i++) add_exp(1'b0, 1'b1, 8'(i), 1'b0);
        run_until_done(1000);
        tick();
        tick();
        chk("s032_grant_idle", {30'd0, grant}, 32'd0);

        // send_busy never rises: ack + err after START_TO cycles, then idle
        do_reset();
        busy_never = 1'b1;
        push_a(1'b1, 8'h5C, 1'b1);
        add_exp(1'b0, 1'b1, 8'h5C, 1'b1);
        run_until_done(100);
        busy_never = 1'b0;
        tick();
        chk("s033_grant_idle", {30'd0, grant}, 32'd0);
        chk("s033_send_en_idle", {31'd0, send_en}, 32'd0);

        // Lock held by A but A stops requesting: B granted at that evaluation
        do_reset();
        busy_len = 3;
        push_a(1'b0, 8'h3C, 1'b1);
        push_b(1'b1, 8'h5A, 1'b0);
        add_exp(1'b0, 1'b0, 8'h3C, 1'b0);
        add_exp(1'b1, 1'b1, 8'h5A, 1'b0);
        run_until_done(200);

        // Reset during WAIT_DONE drops the byte; next request (req dropped
        // mid-byte) still completes with an ack
        do_reset();
        busy_len = 20;
        push_a(1'b1, 8'h11, 1'b0);
        add_exp(1'b0, 1'b1, 8'h11, 1'b0);
        for (int k = 0; k < 20 && !cur_valid; k++) tick();
        chk("s034_started", {31'd0, cur_valid}, 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        clear_models();
        tick();
        chk_all_zero("s034_rst");
        rst = 1'b0;
        tick();
        tick();
        busy_len   = 4;
        a_drop_mid = 1'b1;
        push_a(1'b0, 8'h22, 1'b0);
        add_exp(1'b0, 1'b0, 8'h22, 1'b0);
        run_until_done(200);
        a_drop_mid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
